// File: rtl/serial_paralelo_rx.sv
// Receive-side deserializer: aligns a MSB-first bit stream to the COM symbol and,
// once locked, delivers one recovered byte every 8 bit clocks with a payload flag.
module serial_paralelo_rx #(
  parameter logic [7:0]  COM_SYMBOL = 8'hBC,
  parameter int unsigned BC_NEEDED  = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [3:0] BC_TARGET = 4'(BC_NEEDED);

  state_t     state_q,     state_d;
  logic [6:0] sr_q,        sr_d;
  logic [2:0] bit_cnt_q,   bit_cnt_d;
  logic [3:0] bc_cnt_q,    bc_cnt_d;
  logic [7:0] data_q,      data_d;
  logic       valid_q,     valid_d;
  logic       strobe_q,    strobe_d;
  logic       active_q,    active_d;

  logic [7:0] cb;
  logic       is_com;
  logic       at_boundary;
  logic [3:0] bc_inc;

  // Candidate byte: the seven previously sampled bits plus the bit on the wire now.
  assign cb          = {sr_q, serial_in};
  assign is_com      = (cb == COM_SYMBOL);
  assign at_boundary = (bit_cnt_q == 3'd7);
  assign bc_inc      = bc_cnt_q + 4'd1;

  // NOTE: every signal gets its hold/default value first so no path leaves it
  // unassigned; that is what keeps this combinational block free of latches.
  always_comb begin
    state_d   = state_q;
    sr_d      = cb[6:0];
    bit_cnt_d = bit_cnt_q + 3'd1;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    strobe_d  = 1'b0;
    active_d  = active_q;

    unique case (state_q)
      SEARCH: begin
        // Bit-by-bit hunt; a match also fixes the byte phase.
        if (is_com) begin
          bit_cnt_d = 3'd0;
          bc_cnt_d  = 4'd1;
          if (BC_TARGET == 4'd1) begin
            state_d  = ACTIVE;
            active_d = 1'b1;
          end else begin
            state_d = ALIGN;
          end
        end
      end

      ALIGN: begin
        if (at_boundary) begin
          if (is_com) begin
            if (bc_inc >= BC_TARGET) begin
              bc_cnt_d = BC_TARGET;
              state_d  = ACTIVE;
              active_d = 1'b1;
            end else begin
              bc_cnt_d = bc_inc;
            end
          end else begin
            // The failing byte is dropped; hunting resumes with the next bit.
            state_d  = SEARCH;
            bc_cnt_d = 4'd0;
          end
        end
      end

      ACTIVE: begin
        if (at_boundary) begin
          data_d   = cb;
          valid_d  = !is_com;
          strobe_d = 1'b1;
        end
      end

      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order inside the block.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q   <= SEARCH;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      bc_cnt_q  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
      active_q  <= active_d;
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign byte_strobe = strobe_q;
  assign active      = active_q;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Bench for serial_paralelo_rx: two instances (BC_NEEDED=4 and 1) share one stream;
// directed vectors plus a randomized stream checked against a per-cycle reference.
module tb_serial_paralelo_rx;

  localparam logic [7:0] COM = 8'hBC;

  logic       clk_32f;
  logic       reset;
  logic       serial_in;
  logic [7:0] d4_data, d1_data;
  logic       d4_valid, d1_valid;
  logic       d4_strobe, d1_strobe;
  logic       d4_active, d1_active;

  int n_checks   = 0;
  int n_failures = 0;

  serial_paralelo_rx #(.COM_SYMBOL(COM), .BC_NEEDED(4)) u_dut4 (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .serial_in   (serial_in),
    .data_out    (d4_data),
    .valid_out   (d4_valid),
    .byte_strobe (d4_strobe),
    .active      (d4_active)
  );

  serial_paralelo_rx #(.COM_SYMBOL(COM), .BC_NEEDED(1)) u_dut1 (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .serial_in   (serial_in),
    .data_out    (d1_data),
    .valid_out   (d1_valid),
    .byte_strobe (d1_strobe),
    .active      (d1_active)
  );

  initial begin
    clk_32f = 1'b0;
    forever #5 clk_32f = ~clk_32f;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_failures++;
      $display("FAIL %s at t=%0t: actual=%0h required=%0h", name, $time, actual, expected);
    end
  endtask

  // Reference model: absolute sample index since reset, lock time, and a run count
  // of consecutive COMs; byte boundaries are every 8th sample after the lock.
  typedef enum int {HUNT, WAIT, LIVE} mmode_e;
  int         need      [2] = '{4, 1};
  mmode_e     m_mode    [2];
  int         m_lock_t  [2];
  int         m_run     [2];
  logic [7:0] m_data    [2];
  logic       m_valid   [2];
  logic       m_strobe  [2];
  logic       m_active  [2];
  int         m_t;
  logic [7:0] m_window;

  task automatic model_step(input logic b, input logic r);
    bit boundary;
    if (r) begin
      m_t = 0;
      m_window = 8'h00;
      for (int i = 0; i < 2; i++) begin
        m_mode[i] = HUNT; m_run[i] = 0; m_lock_t[i] = 0;
        m_data[i] = 8'h00; m_valid[i] = 1'b0; m_strobe[i] = 1'b0; m_active[i] = 1'b0;
      end
      return;
    end
    m_t++;
    m_window = {m_window[6:0], b};
    for (int i = 0; i < 2; i++) begin
      m_strobe[i] = 1'b0;
      boundary = (m_t > m_lock_t[i]) && (((m_t - m_lock_t[i]) % 8) == 0);
      case (m_mode[i])
        HUNT: if (m_window == COM) begin
          m_lock_t[i] = m_t;
          m_run[i] = 1;
          if (need[i] == 1) begin m_mode[i] = LIVE; m_active[i] = 1'b1; end
          else m_mode[i] = WAIT;
        end
        WAIT: if (boundary) begin
          if (m_window == COM) begin
            m_run[i]++;
            if (m_run[i] == need[i]) begin m_mode[i] = LIVE; m_active[i] = 1'b1; end
          end else begin
            m_mode[i] = HUNT;
            m_run[i] = 0;
          end
        end
        LIVE: if (boundary) begin
          m_data[i] = m_window;
          m_valid[i] = (m_window != COM);
          m_strobe[i] = 1'b1;
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_model();
    check("d4 data_out",    32'(d4_data),   32'(m_data[0]));
    check("d4 valid_out",   32'(d4_valid),  32'(m_valid[0]));
    check("d4 byte_strobe", 32'(d4_strobe), 32'(m_strobe[0]));
    check("d4 active",      32'(d4_active), 32'(m_active[0]));
    check("d1 data_out",    32'(d1_data),   32'(m_data[1]));
    check("d1 valid_out",   32'(d1_valid),  32'(m_valid[1]));
    check("d1 byte_strobe", 32'(d1_strobe), 32'(m_strobe[1]));
    check("d1 active",      32'(d1_active), 32'(m_active[1]));
  endtask

  // Drive one bit, let the edge sample it, then compare at the falling edge.
  task automatic send_bit(input logic b);
    serial_in = b;
    @(posedge clk_32f);
    model_step(b, reset);
    @(negedge clk_32f);
    compare_model();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int k = 7; k >= 0; k--) send_bit(v[k]);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    send_bit(1'b0);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [7:0] byte_in;
    logic [7:0] exp_data;
    logic       exp_valid;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [7:0] com_v;
    com_v = COM;
    vecs[0] = '{8'hAC, 8'hAC, 1'b1};
    vecs[1] = '{8'hF4, 8'hF4, 1'b1};
    vecs[2] = '{8'hF9, 8'hF9, 1'b1};
    vecs[3] = '{8'hBC, 8'hBC, 1'b0};
    vecs[4] = '{8'h0F, 8'h0F, 1'b1};

    // Test 1: reset held 3 cycles, then four COMs.
    serial_in = 1'b0;
    reset = 1'b1;
    repeat (3) send_bit(1'b0);
    reset = 1'b0;
    check("reset data_out", 32'(d4_data), 32'h00);
    check("reset active", 32'(d4_active), 32'h0);
    check("reset strobe", 32'(d4_strobe), 32'h0);
    repeat (3) send_byte(COM);
    for (int k = 7; k >= 1; k--) send_bit(com_v[k]);
    check("t1 active before last bit", 32'(d4_active), 32'h0);
    send_bit(com_v[0]);
    check("t1 active after 4 COM", 32'(d4_active), 32'h1);
    check("t1 no strobe at lock", 32'(d4_strobe), 32'h0);
    check("t1 data_out untouched", 32'(d4_data), 32'h00);

    // Test 2: table of payload/idle bytes once active.
    for (int i = 0; i < 5; i++) begin
      send_byte(vecs[i].byte_in);
      check($sformatf("t2 strobe[%0d]", i), 32'(d4_strobe), 32'h1);
      check($sformatf("t2 data[%0d]", i),   32'(d4_data),   32'(vecs[i].exp_data));
      check($sformatf("t2 valid[%0d]", i),  32'(d4_valid),  32'(vecs[i].exp_valid));
    end

    // Test 3: an interrupted COM run must restart the count.
    pulse_reset();
    repeat (3) send_byte(COM);
    send_byte(8'hF8);
    check("t3 active after F8", 32'(d4_active), 32'h0);
    repeat (3) send_byte(COM);
    check("t3 active after 3 more COM", 32'(d4_active), 32'h0);
    send_byte(COM);
    check("t3 active after 4th COM", 32'(d4_active), 32'h1);

    // Test 4: three junk bits ahead of the COMs.
    pulse_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    repeat (3) send_byte(COM);
    for (int k = 7; k >= 1; k--) send_bit(com_v[k]);
    check("t4 active before last bit", 32'(d4_active), 32'h0);
    send_bit(com_v[0]);
    check("t4 active after shifted COMs", 32'(d4_active), 32'h1);

    // Test 5: mid-byte reset while active.
    send_byte(8'h5A);
    check("t5 data before reset", 32'(d4_data), 32'h5A);
    check("t5 valid before reset", 32'(d4_valid), 32'h1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    pulse_reset();
    check("t5 data after reset", 32'(d4_data), 32'h00);
    check("t5 valid after reset", 32'(d4_valid), 32'h0);
    check("t5 active after reset", 32'(d4_active), 32'h0);
    check("t5 d1 active after reset", 32'(d1_active), 32'h0);
    repeat (4) send_byte(COM);
    check("t5 active realigned", 32'(d4_active), 32'h1);

    // Test 6: BC_NEEDED=1 instance locks on a single COM.
    pulse_reset();
    send_byte(COM);
    check("t6 d1 active", 32'(d1_active), 32'h1);
    check("t6 d4 still inactive", 32'(d4_active), 32'h0);
    send_byte(8'h12);
    check("t6 d1 strobe", 32'(d1_strobe), 32'h1);
    check("t6 d1 data", 32'(d1_data), 32'h12);
    check("t6 d1 valid", 32'(d1_valid), 32'h1);

    // Randomized stream: junk bits, COM-heavy byte mix, occasional resets.
    pulse_reset();
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 4) == 0) pulse_reset();
      repeat ($urandom_range(0, 7)) send_bit(1'($urandom_range(0, 1)));
      for (int j = 0; j < 12; j++) begin
        if ($urandom_range(0, 9) < 6) send_byte(COM);
        else send_byte(8'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
